// File: rtl/uart_cmd_pkg.sv
// Shared types and widths for the UART command receiver.
package uart_cmd_pkg;

    localparam int DATA_BITS = 8;
    localparam int CMD_W     = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic       {HIGH, LOW}               asm_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART byte receiver: RX synchronizer, mid-bit sampling, one-cycle byte_rdy / frame_err.
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_rdy,
    output logic                 frame_err
);

    localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2 - 1);
    localparam logic [11:0] FULL_CNT = 12'(BAUD_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    if (BAUD_DIV < 16 || BAUD_DIV > 4095) begin : g_baud_chk
        $error("uart_rx_core: BAUD_DIV must be within 16..4095");
    end

    logic             rx_s1, rx_s2, rx_d;
    rx_state_t        state;
    logic [11:0]      baud_cnt;
    logic [2:0]       bit_cnt;
    logic [DATA_BITS:0] shreg;
    logic             done;
    logic             tick;

    assign tick = (baud_cnt == 12'd0);

    // Stop bit lands in shreg[8]; data sits in shreg[7:0] once the frame is done.
    assign rx_byte   = shreg[DATA_BITS-1:0];
    assign byte_rdy  = done &  shreg[DATA_BITS];
    assign frame_err = done & ~shreg[DATA_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            done     <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            done  <= 1'b0;
            if (state != IDLE)
                baud_cnt <= tick ? FULL_CNT : baud_cnt - 12'd1;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s2) begin
                        baud_cnt <= HALF_CNT;
                        state    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= rx_s2 ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_s2, shreg[DATA_BITS:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT)
                            state <= STOP;
                    end
                end
                STOP: begin
                    // Back to IDLE immediately so a back-to-back start bit is not missed.
                    if (tick) begin
                        shreg <= {rx_s2, shreg[DATA_BITS:1]};
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Reassembles received UART bytes into 16-bit commands (high byte first).
// Optional CMD_TIMEOUT_EN: drop a lone high byte after TIMEOUT_CYC idle cycles.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX,
    input  logic             clr_cmd_rdy,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    output logic             frame_err,
    output logic             overrun
);

    if (TIMEOUT_CYC < 2) begin : g_to_chk
        $error("uart_cmd_rx: TIMEOUT_CYC must be at least 2");
    end

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_rdy;
    logic [DATA_BITS-1:0] hi_byte;
    asm_state_t           asm_st;
    logic                 to_hit;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_core (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .rx_byte   (rx_byte),
        .byte_rdy  (byte_rdy),
        .frame_err (frame_err)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (asm_st == LOW) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Held at zero in HIGH, so every entry to LOW starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || asm_st == HIGH)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TO_W'(1);
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_st  <= HIGH;
            hi_byte <= '0;
            cmd     <= '0;
            cmd_rdy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (clr_cmd_rdy)
                cmd_rdy <= 1'b0;
            case (asm_st)
                HIGH: begin
                    if (byte_rdy) begin
                        hi_byte <= rx_byte;
                        asm_st  <= LOW;
                    end
                end
                LOW: begin
                    // Completion beats both a same-cycle clear and a same-cycle timeout.
                    if (byte_rdy) begin
                        cmd     <= {hi_byte, rx_byte};
                        cmd_rdy <= 1'b1;
                        overrun <= cmd_rdy & ~clr_cmd_rdy;
                        asm_st  <= HIGH;
                    end else if (frame_err || to_hit) begin
                        asm_st <= HIGH;
                    end
                end
                default: asm_st <= HIGH;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at BAUD_DIV=16, TIMEOUT_CYC=400.
`timescale 1ns/1ps
module tb_uart_cmd_rx;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy, frame_err, overrun;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0, ov0;

    uart_cmd_rx #(.BAUD_DIV(BD), .TIMEOUT_CYC(400)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun)   ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start + 8 data bits; leaves RX at the stop level on return.
    task automatic send_bits(input logic [7:0] d, input logic stop);
        @(negedge clk) RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = d[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bits(d, stop);
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    // Stop bit of the low byte is sampled at the 155th posedge after its start edge;
    // cmd_rdy must move exactly one edge later.
    task automatic send_cmd_timed(input logic [15:0] w, input logic do_clr, input logic exp_pre);
        send_byte(w[15:8], 1'b1);
        send_bits(w[7:0], 1'b1);
        repeat (11) @(posedge clk);
        #1 chk("rdy_before_done", cmd_rdy, exp_pre);
        if (do_clr) begin
            @(negedge clk) clr_cmd_rdy = 1'b1;
        end
        @(posedge clk);
        #1 chk("rdy_at_done", cmd_rdy, 1'b1);
        if (do_clr) begin
            @(negedge clk) clr_cmd_rdy = 1'b0;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_cmd_rdy = 1'b1;
        @(negedge clk) clr_cmd_rdy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 chk("reset_state", {cmd, cmd_rdy, frame_err, overrun}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);

        // Basic command with exact latency
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_cmd_timed(16'hA53C, 1'b0, 1'b0);
        chk("cmd_a53c", cmd, 16'hA53C);
        chk("a53c_fe", fe_cnt - fe0, 0);
        chk("a53c_ov", ov_cnt - ov0, 0);
        pulse_clr();
        chk("clr_a53c", cmd_rdy, 1'b0);

        // Overrun
        ov0 = ov_cnt;
        send_cmd(16'h1234);
        chk("cmd_1234", cmd, 16'h1234);
        send_cmd(16'hBEEF);
        chk("ovr_count", ov_cnt - ov0, 1);
        chk("cmd_beef", cmd, 16'hBEEF);
        chk("rdy_beef", cmd_rdy, 1'b1);
        pulse_clr();
        chk("clr_rdy", cmd_rdy, 1'b0);
        chk("clr_cmd_hold", cmd, 16'hBEEF);
        pulse_clr();
        chk("clr_when_idle", {cmd, cmd_rdy}, {16'hBEEF, 1'b0});

        // Set and clear in the same cycle: set wins, no overrun
        send_cmd(16'h5A5A);
        ov0 = ov_cnt;
        send_cmd_timed(16'h9966, 1'b1, 1'b1);
        chk("setclr_ov", ov_cnt - ov0, 0);
        chk("cmd_9966", cmd, 16'h9966);
        pulse_clr();

        // Short low glitch while idle
        fe0 = fe_cnt;
        @(negedge clk) RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_fe", fe_cnt - fe0, 0);
        chk("glitch_rdy", cmd_rdy, 1'b0);
        send_cmd(16'h0F0F);
        chk("cmd_0f0f", cmd, 16'h0F0F);
        pulse_clr();

        // Framing error drops the held high byte
        fe0 = fe_cnt; ov0 = ov_cnt;
        send_byte(8'h55, 1'b1);
        send_byte(8'h99, 1'b0);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        chk("ferr_count", fe_cnt - fe0, 1);
        chk("cmd_6677", cmd, 16'h6677);
        chk("ferr_ov", ov_cnt - ov0, 0);

        // Reset in the middle of a byte
        @(negedge clk) RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = i[0];
            repeat (BD) @(negedge clk);
        end
        rst = 1'b1;
        RX = 1'b1;
        @(posedge clk);
        #1 chk("reset_mid", {cmd, cmd_rdy, frame_err, overrun}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_cmd(16'hC001);
        chk("cmd_c001", {cmd, cmd_rdy}, {16'hC001, 1'b1});
        pulse_clr();

        // Inter-byte gap longer than the timeout
        send_byte(8'h12, 1'b1);
        repeat (500) @(negedge clk);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
`ifdef CMD_TIMEOUT_EN
        chk("timeout_cmd", cmd, 16'h3456);
`else
        chk("timeout_cmd", cmd, 16'h1234);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
